// File: rtl/pe_edge_sequencer.sv
// rtl/pe_edge_sequencer.sv - PE edge address, block and channel sequencer for the systolic conv array
// One job per start pulse: psum-in wraps walk blocks/channels, the last psum-out block closes the job.
module pe_edge_sequencer #(
   parameter int W_GROUP = 4,
   parameter int O_GROUP = 4,
   parameter int I_GROUP = W_GROUP + O_GROUP - 1,
   parameter int W_AW    = 2,
   parameter int O_AW    = 2,
   parameter int I_AW    = 3,
   parameter int BLK_CNT = 4,
   parameter int BLK_W   = 3,
   parameter int CH_CNT  = 2,
   parameter int CH_W    = 1
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             clk_en,
   input  logic             start,
   input  logic             en_w,
   input  logic             en_i,
   input  logic             en_o_in,
   input  logic             en_o_out,
   output logic [W_AW-1:0]  w_addr,
   output logic [I_AW-1:0]  i_addr,
   output logic [O_AW-1:0]  o_in_addr,
   output logic [O_AW-1:0]  o_out_addr,
   output logic [BLK_W-1:0] o_in_blk,
   output logic [BLK_W-1:0] o_out_blk,
   output logic [CH_W-1:0]  ch_idx,
   output logic             psum_first,
   output logic             psum_last,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam logic [W_AW-1:0]  W_LAST   = W_AW'(W_GROUP - 1);
   localparam logic [I_AW-1:0]  I_LAST   = I_AW'(I_GROUP - 1);
   localparam logic [O_AW-1:0]  O_LAST   = O_AW'(O_GROUP - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_CNT - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_CNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [W_AW-1:0]  r_w_addr;
   logic [I_AW-1:0]  r_i_addr;
   logic [O_AW-1:0]  r_o_in_addr;
   logic [O_AW-1:0]  r_o_out_addr;
   logic [BLK_W-1:0] r_o_in_blk;
   logic [BLK_W-1:0] r_o_out_blk;
   logic [CH_W-1:0]  r_ch_idx;
   logic             r_out_fin;
   logic             r_err;

   logic w_any_en;
   logic w_in_wrap;
   logic w_out_wrap;
   logic w_in_blk_last;
   logic w_ch_last;
   logic w_final_in;
   logic w_out_fin_set;
   logic w_acc_wio;
   logic w_acc_in;
   logic w_clear;
   logic w_err_set;
   logic w_err_clr;

   assign w_any_en      = en_w | en_i | en_o_in | en_o_out;
   assign w_in_wrap     = en_o_in && (r_o_in_addr == O_LAST);
   assign w_out_wrap    = en_o_out && (r_o_out_addr == O_LAST);
   assign w_in_blk_last = (r_o_in_blk == BLK_LAST);
   assign w_ch_last     = (r_ch_idx == CH_LAST);
   assign w_final_in    = w_in_wrap && w_in_blk_last && w_ch_last;
   assign w_out_fin_set = w_out_wrap && (r_o_out_blk == BLK_LAST) && w_ch_last;

   always_comb begin
      w_state_nxt = r_state;
      w_acc_wio   = 1'b0;
      w_acc_in    = 1'b0;
      w_clear     = 1'b0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_clear     = 1'b1;
               w_err_clr   = 1'b1;
               w_state_nxt = S_RUN;
            end else if (w_any_en) begin
               w_err_set = 1'b1;
            end
         end
         S_RUN: begin
            w_acc_wio = 1'b1;
            w_acc_in  = 1'b1;
            if (w_final_in) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_acc_wio = 1'b1;
            if (en_o_in) w_err_set = 1'b1;
            if (r_out_fin || w_out_fin_set) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (w_any_en) w_err_set = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state <= S_IDLE;
      end else if (clk_en) begin
         r_state <= w_state_nxt;
      end
   end

   // The channel index saturates on the final in-wrap so psum_last stays valid while draining.
   always_ff @(posedge clk) begin
      if (sclr) begin
         r_w_addr     <= '0;
         r_i_addr     <= '0;
         r_o_in_addr  <= '0;
         r_o_out_addr <= '0;
         r_o_in_blk   <= '0;
         r_o_out_blk  <= '0;
         r_ch_idx     <= '0;
         r_out_fin    <= 1'b0;
         r_err        <= 1'b0;
      end else if (clk_en) begin
         if (w_clear) begin
            r_w_addr     <= '0;
            r_i_addr     <= '0;
            r_o_in_addr  <= '0;
            r_o_out_addr <= '0;
            r_o_in_blk   <= '0;
            r_o_out_blk  <= '0;
            r_ch_idx     <= '0;
            r_out_fin    <= 1'b0;
         end else begin
            if (w_acc_wio && en_w)
               r_w_addr <= (r_w_addr == W_LAST) ? '0 : r_w_addr + 1'b1;
            if (w_acc_wio && en_i)
               r_i_addr <= (r_i_addr == I_LAST) ? '0 : r_i_addr + 1'b1;
            if (w_acc_in && en_o_in) begin
               r_o_in_addr <= (r_o_in_addr == O_LAST) ? '0 : r_o_in_addr + 1'b1;
               if (w_in_wrap) begin
                  if (w_in_blk_last) begin
                     r_o_in_blk <= '0;
                     if (!w_ch_last) r_ch_idx <= r_ch_idx + 1'b1;
                  end else begin
                     r_o_in_blk <= r_o_in_blk + 1'b1;
                  end
               end
            end
            if (w_acc_wio && en_o_out) begin
               r_o_out_addr <= (r_o_out_addr == O_LAST) ? '0 : r_o_out_addr + 1'b1;
               if (w_out_wrap)
                  r_o_out_blk <= (r_o_out_blk == BLK_LAST) ? '0 : r_o_out_blk + 1'b1;
            end
            if (w_acc_wio && w_out_fin_set) r_out_fin <= 1'b1;
         end
         if (w_err_clr) begin
            r_err <= 1'b0;
         end else if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_addr     = r_w_addr;
   assign i_addr     = r_i_addr;
   assign o_in_addr  = r_o_in_addr;
   assign o_out_addr = r_o_out_addr;
   assign o_in_blk   = r_o_in_blk;
   assign o_out_blk  = r_o_out_blk;
   assign ch_idx     = r_ch_idx;
   assign psum_first = (r_ch_idx == '0);
   assign psum_last  = w_ch_last;
   assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done       = (r_state == S_DONE);
   assign err        = r_err;
endmodule

// File: tb/tb_pe_edge_sequencer.sv
// tb/tb_pe_edge_sequencer.sv - self-checking bench for pe_edge_sequencer
// Reference model feeds a scoreboard queue; a vector table and directed job sequences add fixed expectations.
module tb_pe_edge_sequencer;
   logic       clk = 1'b0;
   logic       sclr, clk_en, start, en_w, en_i, en_o_in, en_o_out;
   logic [1:0] w_addr, o_in_addr, o_out_addr;
   logic [2:0] i_addr, o_in_blk, o_out_blk;
   logic [0:0] ch_idx;
   logic       psum_first, psum_last, busy, done, err;

   pe_edge_sequencer dut (
      .clk(clk), .sclr(sclr), .clk_en(clk_en), .start(start),
      .en_w(en_w), .en_i(en_i), .en_o_in(en_o_in), .en_o_out(en_o_out),
      .w_addr(w_addr), .i_addr(i_addr), .o_in_addr(o_in_addr), .o_out_addr(o_out_addr),
      .o_in_blk(o_in_blk), .o_out_blk(o_out_blk), .ch_idx(ch_idx),
      .psum_first(psum_first), .psum_last(psum_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic sclr, ce, start, ew, ei, eoi, eoo;} in_t;
   typedef struct packed {
      logic [1:0] w; logic [2:0] i; logic [1:0] oi, oo; logic [2:0] ib, ob;
      logic ch, pf, pl, busy, done, err;
   } out_t;
   typedef struct {in_t stim; out_t exp;} vec_t;

   vec_t tbl[$];
   out_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   int m_st, m_w, m_i, m_oi, m_oo, m_ib, m_ob, m_ch;
   bit m_fin, m_err;

   function automatic in_t mi(bit s, bit c, bit st, bit ew, bit ei, bit eoi, bit eoo);
      in_t r;
      r = {s, c, st, ew, ei, eoi, eoo};
      return r;
   endfunction

   function automatic out_t ov(int w, int i, int oi, int oo, int ib, int ob, int ch,
                               bit bsy, bit dn, bit er);
      out_t o;
      o.w = 2'(w); o.i = 3'(i); o.oi = 2'(oi); o.oo = 2'(oo);
      o.ib = 3'(ib); o.ob = 3'(ob); o.ch = 1'(ch);
      o.pf = (ch == 0); o.pl = (ch == 1);
      o.busy = bsy; o.done = dn; o.err = er;
      return o;
   endfunction

   function automatic out_t m_out();
      return ov(m_w, m_i, m_oi, m_oo, m_ib, m_ob, m_ch, (m_st == 1 || m_st == 2), (m_st == 3), m_err);
   endfunction

   task automatic m_clear();
      m_w = 0; m_i = 0; m_oi = 0; m_oo = 0; m_ib = 0; m_ob = 0; m_ch = 0; m_fin = 0;
   endtask

   task automatic m_step(input in_t v);
      bit any, fin_now, in_final;
      any = v.ew | v.ei | v.eoi | v.eoo;
      fin_now = 0; in_final = 0;
      if (v.sclr) begin
         m_clear(); m_st = 0; m_err = 0;
      end else if (v.ce) begin
         case (m_st)
            0: if (v.start) begin m_clear(); m_err = 0; m_st = 1; end
               else if (any) m_err = 1;
            1, 2: begin
               if (v.ew) m_w = (m_w + 1) % 4;
               if (v.ei) m_i = (m_i + 1) % 7;
               if (v.eoo) begin
                  if (m_oo == 3) begin
                     if (m_ob == 3 && m_ch == 1) fin_now = 1;
                     m_ob = (m_ob + 1) % 4;
                  end
                  m_oo = (m_oo + 1) % 4;
               end
               if (v.eoi && m_st == 2) m_err = 1;
               else if (v.eoi) begin
                  if (m_oi == 3) begin
                     if (m_ib == 3) begin
                        if (m_ch == 1) in_final = 1; else m_ch = m_ch + 1;
                     end
                     m_ib = (m_ib + 1) % 4;
                  end
                  m_oi = (m_oi + 1) % 4;
               end
               if (fin_now) m_fin = 1;
               if (m_st == 1 && in_final) m_st = 2;
               else if (m_st == 2 && m_fin) m_st = 3;
            end
            default: begin if (any) m_err = 1; m_st = 0; end
         endcase
      end
   endtask

   task automatic cmp(input string nm, input out_t g, input out_t e);
      n_vec++;
      if (g !== e) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", nm, g, e);
      end
   endtask

   task automatic chk(input string nm, input int g, input int e);
      n_vec++;
      if (g != e) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", nm, g, e);
      end
   endtask

   task automatic cyc(input in_t v, output out_t got);
      out_t e;
      sclr = v.sclr; clk_en = v.ce; start = v.start;
      en_w = v.ew; en_i = v.ei; en_o_in = v.eoi; en_o_out = v.eoo;
      m_step(v);
      exp_q.push_back(m_out());
      @(posedge clk);
      #1;
      got = {w_addr, i_addr, o_in_addr, o_out_addr, o_in_blk, o_out_blk, ch_idx,
             psum_first, psum_last, busy, done, err};
      e = exp_q.pop_front();
      cmp("sb", got, e);
   endtask

   task automatic add(input in_t s, input out_t e);
      vec_t v;
      v.stim = s; v.exp = e;
      tbl.push_back(v);
   endtask

   initial begin
      out_t g;
      in_t  idle, oin, oout, both;
      int   dcnt;
      idle = mi(0, 1, 0, 0, 0, 0, 0);
      oin  = mi(0, 1, 0, 0, 0, 1, 0);
      oout = mi(0, 1, 0, 0, 0, 0, 1);
      both = mi(0, 1, 0, 0, 0, 1, 1);
      m_clear(); m_st = 0; m_err = 0;

      add(mi(1, 0, 0, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(mi(1, 0, 0, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(mi(0, 1, 0, 0, 1, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(mi(0, 1, 0, 1, 0, 1, 1), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(mi(0, 1, 1, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 7; k++)
         add(mi(0, 1, 0, 0, 1, 0, 0), ov(0, k % 7, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 4; k++)
         add(mi(0, 1, 0, 1, 0, 0, 0), ov(k % 4, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      add(mi(0, 1, 0, 0, 1, 1, 1), ov(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
      for (int k = 0; k < 5; k++)
         add(mi(0, 0, 1, 1, 1, 1, 1), ov(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
      add(mi(1, 0, 0, 1, 1, 1, 1), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(mi(1, 1, 0, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[k]) begin
         cyc(tbl[k].stim, g);
         cmp($sformatf("tbl[%0d]", k), g, tbl[k].exp);
      end

      // full job with default sizes
      cyc(mi(0, 1, 1, 0, 0, 0, 0), g);
      for (int k = 1; k <= 32; k++) begin
         cyc(oin, g);
         if (k == 15) chk("ch_before_word16", g.ch, 0);
         if (k == 16) chk("ch_after_word16", g.ch, 1);
      end
      chk("busy_after_word32", g.busy, 1);
      chk("blk_after_word32", g.ib, 0);
      cyc(oin, g);
      chk("drain_oin_addr_hold", g.oi, 0);
      chk("drain_oin_err", g.err, 1);
      chk("drain_psum_last", g.pl, 1);
      for (int k = 1; k <= 16; k++) begin
         cyc(oout, g);
         if (k == 15) chk("done_early", g.done, 0);
      end
      chk("job_done", g.done, 1);
      chk("job_busy_fall", g.busy, 0);
      cyc(idle, g);
      chk("done_one_cycle", g.done, 0);
      cyc(mi(0, 1, 1, 0, 0, 0, 0), g);
      chk("start_clears_err", g.err, 0);
      chk("start_psum_first", g.pf, 1);

      // final in-wrap coincides with out_fin setting
      for (int k = 0; k < 16; k++) cyc(oin, g);
      for (int k = 0; k < 15; k++) cyc(both, g);
      cyc(both, g);
      chk("simul_busy", g.busy, 1);
      chk("simul_done_not_yet", g.done, 0);
      dcnt = 0;
      for (int k = 0; k < 4; k++) begin
         cyc(idle, g);
         if (k == 0) chk("simul_done_next", g.done, 1);
         dcnt += int'(g.done);
      end
      chk("simul_done_once", dcnt, 1);

      for (int k = 0; k < 600; k++) begin
         in_t v;
         v.sclr  = ($urandom_range(99) == 0);
         v.ce    = ($urandom_range(7) != 0);
         v.start = ($urandom_range(15) == 0);
         v.ew    = 1'($urandom_range(1));
         v.ei    = 1'($urandom_range(1));
         v.eoi   = ($urandom_range(3) != 0);
         v.eoo   = 1'($urandom_range(1));
         cyc(v, g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
